// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// ---------------------------------------------------------------------------
// APB initiator. This block accepts single-word commands on a valid/ready
// request port and runs each one as an APB SETUP/ACCESS transfer. It returns
// read data and status on a valid/ready response port. Only one transfer is
// in flight at a time.
//
// A stall counter watches the ACCESS phase. If a slave holds PREADY low for
// TIMEOUT_CYCLES ACCESS cycles, the transfer is aborted and a timeout
// response is returned. Setting TIMEOUT_CYCLES to 0 disables this check.
//
// Ports
//   HCLK, HRESET                      clock, async active-high reset
//   req_valid/req_ready               command handshake
//   req_addr/req_write/req_wdata      command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata/rsp_err/rsp_timeout     response payload
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE  APB request (all registered)
//   PRDATA/PREADY/PSLVERR             APB completion (sampled in ACCESS only)
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  // This is the counter value seen in the last allowed ACCESS cycle. The
  // counter starts at 0 in the first ACCESS cycle, so abort happens after
  // exactly TIMEOUT_CYCLES ACCESS cycles.
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t                    state_r;
  state_t                    state_s;
  logic [15:0]               stall_cnt_r;
  logic [15:0]               stall_cnt_s;
  logic [APB_ADDR_WIDTH-1:0] paddr_s;
  logic [31:0]               pwdata_s;
  logic                      pwrite_s;
  logic                      psel_s;
  logic                      penable_s;
  logic                      rsp_valid_s;
  logic [31:0]               rsp_rdata_s;
  logic                      rsp_err_s;
  logic                      rsp_timeout_s;

  // The command port is open only while idle.
  assign req_ready = (state_r == ST_IDLE);

  // Next-state and next-output decode for the transfer sequencer.
  always_comb begin
    state_s       = state_r;
    stall_cnt_s   = stall_cnt_r;
    paddr_s       = PADDR;
    pwdata_s      = PWDATA;
    pwrite_s      = PWRITE;
    psel_s        = PSEL;
    penable_s     = PENABLE;
    rsp_valid_s   = rsp_valid;
    rsp_rdata_s   = rsp_rdata;
    rsp_err_s     = rsp_err;
    rsp_timeout_s = rsp_timeout;

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_s  = req_addr;
          pwdata_s = req_wdata;
          pwrite_s = req_write;
          psel_s   = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_SETUP: begin
        penable_s   = 1'b1;
        stall_cnt_s = 16'd0;
        state_s     = ST_ACCESS;
      end

      ST_ACCESS: begin
        // Completion is checked first, so PREADY in the last allowed cycle
        // wins over the timeout.
        if (PREADY) begin
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_rdata_s   = PWRITE ? 32'd0 : PRDATA;
          rsp_err_s     = PSLVERR;
          rsp_timeout_s = 1'b0;
          rsp_valid_s   = 1'b1;
          state_s       = ST_RESP;
        end else begin
          if (stall_cnt_r != 16'hFFFF) begin
            stall_cnt_s = stall_cnt_r + 16'd1;
          end else begin
            stall_cnt_s = stall_cnt_r;
          end
          if (TIMEOUT_EN && (stall_cnt_r == TIMEOUT_LAST)) begin
            psel_s        = 1'b0;
            penable_s     = 1'b0;
            rsp_rdata_s   = 32'd0;
            rsp_err_s     = 1'b1;
            rsp_timeout_s = 1'b1;
            rsp_valid_s   = 1'b1;
            state_s       = ST_RESP;
          end else begin
            state_s       = ST_ACCESS;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_RESP;
        end
      end

      default: begin
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State register plus all registered outputs. The async reset drops the
  // bus and discards any pending transfer or response immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= ST_IDLE;
      stall_cnt_r <= 16'd0;
      PADDR       <= '0;
      PWDATA      <= 32'd0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_r     <= state_s;
      stall_cnt_r <= stall_cnt_s;
      PADDR       <= paddr_s;
      PWDATA      <= pwdata_s;
      PWRITE      <= pwrite_s;
      PSEL        <= psel_s;
      PENABLE     <= penable_s;
      rsp_valid   <= rsp_valid_s;
      rsp_rdata   <= rsp_rdata_s;
      rsp_err     <= rsp_err_s;
      rsp_timeout <= rsp_timeout_s;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
// ---------------------------------------------------------------------------
// Self-checking bench for apb_cmd_master, instantiated with TIMEOUT_CYCLES=8.
// The bench acts as the APB slave. It returns PREADY after a chosen number of
// wait states and drives random junk on the APB inputs whenever the master
// must ignore them. Expected responses come from a table of directed vectors
// and from a reference model of the transfer rules.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

  localparam int AW = 12;
  localparam int TO = 8;

  logic          HCLK;
  logic          HRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int errors = 0;
  int checks = 0;

  apb_cmd_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [31:0]   wdata;
    int            waits;      // PREADY=0 cycles before PREADY=1
    logic          slverr;
    logic [31:0]   prdata;
    int            rsp_delay;  // cycles rsp_ready stays low
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_access;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_junk();
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
  endtask

  // Reference model. A slave that stalls for at least TO cycles is cut off
  // after exactly TO ACCESS cycles. Otherwise the transfer takes waits+1
  // ACCESS cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   to;
    r  = v;
    to = (TO != 0) && (v.waits >= TO);
    r.exp_to     = to;
    r.exp_access = to ? TO : v.waits + 1;
    r.exp_err    = to ? 1'b1 : v.slverr;
    r.exp_rdata  = (to || v.wr) ? 32'd0 : v.prdata;
    return r;
  endfunction

  // This task runs one full transfer, starting and ending at a negedge with
  // the DUT idle.
  task automatic do_xfer(input vec_t v, input string tag);
    int n;
    int guard;
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.wr;
    req_wdata = v.wdata;
    drive_junk();
    check({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
    @(negedge HCLK);
    // SETUP cycle. The request inputs now change, but the APB side must not
    // follow them.
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    req_write = 1'($urandom);
    drive_junk();
    check({tag, " setup_psel"}, 32'(PSEL), 32'd1);
    check({tag, " setup_penable"}, 32'(PENABLE), 32'd0);
    check({tag, " setup_paddr"}, 32'(PADDR), 32'(v.addr));
    check({tag, " setup_pwrite"}, 32'(PWRITE), 32'(v.wr));
    check({tag, " setup_pwdata"}, PWDATA, v.wdata);
    check({tag, " setup_req_ready"}, 32'(req_ready), 32'd0);
    n = 0;
    guard = 0;
    @(negedge HCLK);
    while (PSEL === 1'b1 && PENABLE === 1'b1 && guard < 64) begin
      n++;
      guard++;
      check({tag, " access_paddr"}, 32'(PADDR), 32'(v.addr));
      check({tag, " access_pwrite"}, 32'(PWRITE), 32'(v.wr));
      check({tag, " access_pwdata"}, PWDATA, v.wdata);
      if (n > v.waits) begin
        PREADY  = 1'b1;
        PRDATA  = v.prdata;
        PSLVERR = v.slverr;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end
      @(negedge HCLK);
    end
    drive_junk();
    check({tag, " access_cycles"}, 32'(n), 32'(v.exp_access));
    check({tag, " done_psel"}, 32'(PSEL), 32'd0);
    check({tag, " done_penable"}, 32'(PENABLE), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
    // Hold the response while a new command waits, which must not be taken.
    req_valid = 1'b1;
    req_addr  = AW'($urandom);
    rsp_ready = 1'b0;
    for (int i = 0; i < v.rsp_delay; i++) begin
      @(negedge HCLK);
      drive_junk();
      check({tag, " hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold_rsp_rdata"}, rsp_rdata, v.exp_rdata);
      check({tag, " hold_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
      check({tag, " hold_rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
      check({tag, " hold_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " hold_psel"}, 32'(PSEL), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge HCLK);
    // The command still pending at the handshake edge must not have been
    // accepted.
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, " post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " post_psel"}, 32'(PSEL), 32'd0);
    check({tag, " post_paddr_hold"}, 32'(PADDR), 32'(v.addr));
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    PRDATA    = 32'd0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Directed vectors: addr, wr, wdata, waits, slverr, prdata, delay, expected.
    vecs[0] = '{addr:12'h004, wr:1'b1, wdata:32'h0000_0005, waits:0, slverr:1'b0,
                prdata:32'h1234_5678, rsp_delay:0, exp_rdata:32'd0, exp_err:1'b0,
                exp_to:1'b0, exp_access:1};
    vecs[1] = '{addr:12'h020, wr:1'b0, wdata:32'h0, waits:3, slverr:1'b0,
                prdata:32'hDEAD_BEEF, rsp_delay:0, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0,
                exp_to:1'b0, exp_access:4};
    vecs[2] = '{addr:12'h030, wr:1'b0, wdata:32'h0, waits:1, slverr:1'b1,
                prdata:32'hCAFE_0001, rsp_delay:1, exp_rdata:32'hCAFE_0001, exp_err:1'b1,
                exp_to:1'b0, exp_access:2};
    vecs[3] = '{addr:12'h040, wr:1'b0, wdata:32'h0, waits:20, slverr:1'b0,
                prdata:32'h5555_AAAA, rsp_delay:0, exp_rdata:32'd0, exp_err:1'b1,
                exp_to:1'b1, exp_access:8};
    vecs[4] = '{addr:12'h044, wr:1'b0, wdata:32'h0, waits:7, slverr:1'b0,
                prdata:32'h0BAD_F00D, rsp_delay:0, exp_rdata:32'h0BAD_F00D, exp_err:1'b0,
                exp_to:1'b0, exp_access:8};
    vecs[5] = '{addr:12'hFFC, wr:1'b1, wdata:32'hFFFF_FFFF, waits:8, slverr:1'b0,
                prdata:32'h1111_2222, rsp_delay:2, exp_rdata:32'd0, exp_err:1'b1,
                exp_to:1'b1, exp_access:8};
    vecs[6] = '{addr:12'h008, wr:1'b1, wdata:32'hA5A5_0F0F, waits:2, slverr:1'b1,
                prdata:32'h7777_7777, rsp_delay:5, exp_rdata:32'd0, exp_err:1'b1,
                exp_to:1'b0, exp_access:3};
    vecs[7] = '{addr:12'h00C, wr:1'b0, wdata:32'h0, waits:0, slverr:1'b0,
                prdata:32'hA5A5_A5A5, rsp_delay:5, exp_rdata:32'hA5A5_A5A5, exp_err:1'b0,
                exp_to:1'b0, exp_access:1};

    // Reset state, observed with no clock edge having occurred.
    #1;
    check("reset_psel", 32'(PSEL), 32'd0);
    check("reset_penable", 32'(PENABLE), 32'd0);
    check("reset_pwrite", 32'(PWRITE), 32'd0);
    check("reset_paddr", 32'(PADDR), 32'd0);
    check("reset_pwdata", PWDATA, 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);

    for (int i = 0; i < 8; i++) begin
      do_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of ACCESS while the slave stalls.
    req_valid = 1'b1;
    req_addr  = 12'h050;
    req_write = 1'b0;
    @(negedge HCLK);
    req_valid = 1'b0;
    PREADY    = 1'b0;
    @(negedge HCLK);
    check("rst_mid pre_penable", 32'(PENABLE), 32'd1);
    PREADY = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    check("rst_mid psel", 32'(PSEL), 32'd0);
    check("rst_mid penable", 32'(PENABLE), 32'd0);
    check("rst_mid req_ready", 32'(req_ready), 32'd1);
    @(negedge HCLK);
    PREADY = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      drive_junk();
      check("rst_mid no_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid idle_psel", 32'(PSEL), 32'd0);
      check("rst_mid req_ready", 32'(req_ready), 32'd1);
    end

    // Randomized transfers checked against the reference model.
    for (int i = 0; i < 30; i++) begin
      rv.addr      = AW'($urandom);
      rv.wr        = 1'($urandom);
      rv.wdata     = $urandom;
      rv.waits     = int'($urandom_range(0, 11));
      rv.slverr    = 1'($urandom);
      rv.prdata    = $urandom;
      rv.rsp_delay = int'($urandom_range(0, 3));
      rv = model(rv);
      do_xfer(rv, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator: turns single-word requests from a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response port.
- Drives the slave-side register interfaces of the APB peripherals (SPI master register block and siblings) from a sequencer or debug bridge.
- Includes a PREADY stall timeout, so a hung slave cannot lock the bus.

Parameters:
- APB_ADDR_WIDTH, 12: width of PADDR and req_addr (4KB slave window).
- TIMEOUT_CYCLES, 255: maximum number of ACCESS cycles with PREADY=0 before abort. 0 disables the timeout. Legal range 0..65535.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  asynchronous reset, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_addr  in  APB_ADDR_WIDTH  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data (0 for writes and timeouts).
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (async, HRESET=1, takes effect immediately, no clock needed):
  - state = IDLE.
  - All outputs registered and 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, stall counter.
  - req_ready = 1 after reset (decoded from state==IDLE).
- Reset mid-transfer:
  - PSEL/PENABLE drop in the same instant.
  - Pending command and response are discarded; no response is produced.
- States: IDLE, SETUP, ACCESS, RESP. One transfer at a time; no pipelining.
- IDLE:
  - req_ready = 1; all other states have req_ready = 0.
  - On req_valid: register req_addr -> PADDR, req_wdata -> PWDATA, req_write -> PWRITE.
  - Next cycle: PSEL=1, PENABLE=0, state SETUP.
  - PADDR/PWDATA/PWRITE keep their last values while idle; they change only on acceptance.
- SETUP: exactly one cycle. Next cycle PENABLE=1, state ACCESS, stall counter cleared to 0.
- ACCESS, PREADY=1 (transfer completes this cycle):
  - Next cycle: PSEL=0, PENABLE=0.
  - rsp_rdata = PWRITE ? 0 : PRDATA.
  - rsp_err = PSLVERR, rsp_timeout = 0.
  - rsp_valid = 1, state RESP.
- ACCESS, PREADY=0:
  - Stall counter increments (16 bit, saturating).
  - If TIMEOUT_CYCLES != 0 and the counter already equals TIMEOUT_CYCLES-1 in this cycle, abort: next cycle PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, state RESP.
  - Total ACCESS cycles before abort = TIMEOUT_CYCLES.
  - PREADY=1 in the final allowed cycle completes normally; completion wins over timeout.
- PADDR, PWDATA and PWRITE are stable from SETUP through the last ACCESS cycle.
- RESP:
  - rsp_valid held, rsp_* stable, until rsp_ready=1; then next cycle rsp_valid=0, state IDLE.
  - A new command cannot be accepted in the same cycle as the response handshake.
- Latency: with zero wait states and rsp_ready tied high:
  - accept cycle T, SETUP T+1, ACCESS T+2, rsp_valid T+3, req_ready again T+4.
  - Throughput: one transfer per 4 cycles.
- PSLVERR, PRDATA and PREADY are ignored outside ACCESS.
- req_addr is passed unmodified; the slave decodes word address PADDR[5:2].

Test Plan:
- Write 0x0000_0005 to 0x004, slave PREADY=1 -> one SETUP cycle (PSEL=1, PENABLE=0), one ACCESS cycle (PENABLE=1, PWRITE=1, PADDR=0x004); rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read 0x020, slave returns PRDATA=0xDEAD_BEEF after 3 wait states -> 4 ACCESS cycles; PADDR stable throughout; rsp_rdata=0xDEAD_BEEF, rsp_err=0, rsp_timeout=0.
- Read with PSLVERR=1 on the completing cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA value.
- TIMEOUT_CYCLES=8, PREADY held 0 -> exactly 8 ACCESS cycles, then PSEL=0; response rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- TIMEOUT_CYCLES=8, PREADY=1 on the 8th ACCESS cycle -> normal completion, rsp_timeout=0.
- rsp_ready held 0 for 5 cycles with req_valid=1 -> rsp_* stable and req_ready=0 throughout. Separately, HRESET asserted during ACCESS -> PSEL=PENABLE=0 immediately, no rsp_valid afterwards, req_ready=1 after release.
